// File: rtl/seg_pkg.sv
// seg_pkg: shared types and constants for the segment display frame buffer.
`default_nettype none

package seg_pkg;

   localparam int DIGITS                 = 4;
   localparam int NIBBLE_W               = 4;
   localparam int TIMEOUT_CYCLES_DEFAULT = 131072;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_PENDING = 2'd1,
      ST_COMMIT  = 2'd2
   } state_t;

endpackage

`default_nettype wire

// File: rtl/seg_lz_mask.sv
// seg_lz_mask: leading-zero blank mask; digit 0 is never blanked.
`default_nettype none

module seg_lz_mask
   import seg_pkg::*;
(
   input  logic [DIGITS*NIBBLE_W-1:0] i_value,
   input  logic                       i_en,
   output logic [DIGITS-1:0]          o_mask
);

   // A digit is blanked only while every nibble to its left (inclusive) is zero.
   always_comb begin
      logic lead;
      o_mask = '0;
      lead   = i_en;
      for (int d = DIGITS - 1; d > 0; d--) begin
         lead      = lead & (i_value[d*NIBBLE_W +: NIBBLE_W] == '0);
         o_mask[d] = lead;
      end
   end

endmodule

`default_nettype wire

// File: rtl/seg_frame_buf.sv
// seg_frame_buf: shadow-buffers a display value and commits it at the next
// scan-frame boundary, or after TIMEOUT_CYCLES if no frame_tick arrives.
`default_nettype none

module seg_frame_buf
   import seg_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
)
(
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [DIGITS*NIBBLE_W-1:0] in_data,
   input  logic                       in_blank_lz,
   input  logic                       frame_tick,
   output logic [DIGITS*NIBBLE_W-1:0] disp_value,
   output logic [DIGITS-1:0]          disp_blank,
   output logic                       disp_valid,
   output logic                       timeout_flag
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   state_t                       r_state;
   state_t                       w_next;
   logic [DIGITS*NIBBLE_W-1:0]   r_shadow_data;
   logic                         r_shadow_lz;
   logic [CNT_W-1:0]             r_wait_cnt;
   logic [DIGITS-1:0]            w_mask;
   logic                         w_accept;
   logic                         w_timeout;

   assign in_ready  = (r_state != ST_COMMIT);
   assign w_accept  = in_valid & in_ready;
   assign w_timeout = (r_state == ST_PENDING) & ~frame_tick & (r_wait_cnt == C_CNT_LAST);

   seg_lz_mask u_lz_mask (
      .i_value (r_shadow_data),
      .i_en    (r_shadow_lz),
      .o_mask  (w_mask)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE:    if (w_accept) w_next = ST_PENDING;
         ST_PENDING: if (frame_tick || w_timeout) w_next = ST_COMMIT;
         ST_COMMIT:  w_next = ST_IDLE;
         default:    w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= ST_IDLE;
         r_shadow_data <= '0;
         r_shadow_lz   <= 1'b0;
         r_wait_cnt    <= '0;
         disp_value    <= '0;
         disp_blank    <= '0;
         disp_valid    <= 1'b0;
         timeout_flag  <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_shadow_data <= in_data;
            r_shadow_lz   <= in_blank_lz;
         end
         // Counter sits at zero outside PENDING; it leaves PENDING at C_CNT_LAST so never wraps.
         if (r_state != ST_PENDING) begin
            r_wait_cnt <= '0;
         end else if (r_wait_cnt != C_CNT_LAST) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
         end
         if (w_timeout) begin
            timeout_flag <= 1'b1;
         end
         if (r_state == ST_COMMIT) begin
            disp_value <= r_shadow_data;
            disp_blank <= w_mask;
            disp_valid <= 1'b1;
         end
      end
   end

endmodule

`default_nettype wire

// File: doc/seg_frame_buf.md
SEG_FRAME_BUF -- requirements
Module: seg_frame_buf

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 131072, the maximum cycles a pending value waits for frame_tick before a forced commit.
REQ-002 clk  input  1  single clock; all logic rising-edge.
REQ-003 rst_n  input  1  synchronous active-low reset.
REQ-004 in_valid  input  1  producer offers in_data/in_blank_lz.
REQ-005 in_ready  output  1  block can accept; transfer occurs when in_valid and in_ready are both high at a rising edge.
REQ-006 in_data  input  16  four hex nibbles; [15:12] is digit 3 (leftmost), [3:0] is digit 0.
REQ-007 in_blank_lz  input  1  leading-zero suppression request, travels with in_data.
REQ-008 frame_tick  input  1  one-cycle pulse from the downstream scanner at the start of each scan frame (digit select returns to 0).
REQ-009 disp_value  output  16  registered value presented to the scanner.
REQ-010 disp_blank  output  4  registered per-digit blank mask; bit n blanks digit n.
REQ-011 disp_valid  output  1  high once the first value has been committed.
REQ-012 timeout_flag  output  1  sticky; set when any commit was forced by timeout.

Function
REQ-013 The state machine SHALL have states IDLE, PENDING, COMMIT.
REQ-014 in_ready SHALL be 1 in IDLE and PENDING and 0 in COMMIT (combinational from state).
REQ-015 An accepted transfer SHALL write in_data and in_blank_lz into a shadow register; last write wins.
REQ-016 IDLE: on accept -> PENDING; frame_tick in IDLE SHALL be ignored.
REQ-017 PENDING: frame_tick -> COMMIT; a transfer accepted in the same cycle SHALL overwrite the shadow and be the value committed.
REQ-018 PENDING: a wait counter SHALL clear on entry and increment each PENDING cycle; on reaching TIMEOUT_CYCLES-1 without frame_tick -> COMMIT and set timeout_flag.
REQ-019 Transfers accepted in PENDING SHALL NOT restart the wait counter.
REQ-020 COMMIT (exactly one cycle): disp_value <= shadow data, disp_blank <= computed mask, disp_valid <= 1; next state IDLE.
REQ-021 Mask rule when blank_lz=1: digit 3 blanked if nibble3==0; digit 2 if nibbles 3..2 ==0; digit 1 if nibbles 3..1 ==0; digit 0 never blanked. When blank_lz=0 the mask SHALL be 4'b0000.
REQ-022 disp_value/disp_blank SHALL change only on the COMMIT edge, so the scanner never sees a mid-frame update except on timeout.
REQ-023 Latency: value accepted in PENDING with frame_tick in the same cycle SHALL appear on disp_value 2 edges after acceptance.
REQ-024 The wait counter SHALL be wide enough for TIMEOUT_CYCLES-1 and SHALL never wrap.

Reset
REQ-025 While rst_n=0 at a rising edge: state IDLE, shadow 0, wait counter 0, disp_value 16'h0000, disp_blank 4'b0000, disp_valid 0, timeout_flag 0.
REQ-026 Reset mid-PENDING or mid-COMMIT SHALL discard the pending value; no commit occurs.
REQ-027 timeout_flag SHALL clear only by reset.

Structure
REQ-028 Package seg_pkg SHALL hold the state enum, DIGITS=4, NIBBLE_W=4 and the default TIMEOUT_CYCLES constant.
REQ-029 Leading-zero mask logic SHALL be a combinational sub-module seg_lz_mask (16-bit value + enable in, 4-bit mask out).
REQ-030 Total RTL SHALL be 120-400 lines.

Verification
REQ-031 Reset, then in_data=16'h00A5, blank_lz=1, frame_tick 3 cycles later -> disp_value=16'h00A5, disp_blank=4'b1100, disp_valid=1, timeout_flag=0.
REQ-032 Accept 16'h1234 then 16'h0007 (blank_lz=1) before frame_tick -> single commit of 16'h0007, disp_blank=4'b1110.
REQ-033 Accept 16'hBEEF with frame_tick in the same cycle from PENDING -> disp_value=16'hBEEF two edges later; in_ready=0 exactly in the COMMIT cycle.
REQ-034 TIMEOUT_CYCLES=16, accept 16'h0000 blank_lz=1, no frame_tick -> commit after 16 PENDING cycles, disp_blank=4'b1110, timeout_flag=1 and stays 1 after later normal commits.
REQ-035 rst_n=0 asserted while PENDING with 16'hFFFF -> outputs return to reset values; later frame_tick causes no commit.
REQ-036 frame_tick pulses in IDLE with no transfer -> disp_* unchanged, state remains IDLE.
